// File: rtl/fp_div_pkg.sv
// Shared types, constants and constant builders for the iterative divider.
package fp_div_pkg;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operand classification. Subnormals are flushed, so they read as zero.
  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp_class_t;

  // Widest packed format the constant builders below can produce.
  localparam int FP_MAX_W = 64;

  // Exponent bias 2^(expo_w-1)-1.
  function automatic int exp_bias(input int expo_w);
    return (1 << (expo_w - 1)) - 1;
  endfunction

  // Number of quotient bits: hidden bit, stored fraction, round bit.
  function automatic int quo_w(input int mant_w);
    return mant_w + 2;
  endfunction

  // Quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [FP_MAX_W-1:0] qnan_bits(input int expo_w, input int mant_w);
    logic [FP_MAX_W-1:0] r;
    r = ((64'd1 << expo_w) - 64'd1) << mant_w;
    r = r | (64'd1 << (mant_w - 1));
    return r;
  endfunction

  // Signed infinity: exponent all ones, fraction zero.
  function automatic logic [FP_MAX_W-1:0] inf_bits(input logic sign, input int expo_w,
                                                   input int mant_w);
    logic [FP_MAX_W-1:0] r;
    r = ((64'd1 << expo_w) - 64'd1) << mant_w;
    r = r | ({63'd0, sign} << (expo_w + mant_w));
    return r;
  endfunction

  // Signed zero.
  function automatic logic [FP_MAX_W-1:0] zero_bits(input logic sign, input int expo_w,
                                                    input int mant_w);
    return {63'd0, sign} << (expo_w + mant_w);
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
module div_iter_step #(
  parameter int MANT_W = 23
) (
  input  logic [MANT_W+1:0] i_rem,
  input  logic [MANT_W:0]   i_mb,
  output logic              o_q_bit,
  output logic [MANT_W+1:0] o_rem
);

  localparam int RW = MANT_W + 2;

  logic [RW-1:0] w_mb_ext;
  logic [RW-1:0] w_diff;
  logic [RW-1:0] w_sel;

  // rem < 2*mb is invariant, so the shifted result always fits in RW bits.
  always_comb begin
    w_mb_ext = {1'b0, i_mb};
    w_diff   = i_rem - w_mb_ext;
    o_q_bit  = (i_rem >= w_mb_ext);
    w_sel    = o_q_bit ? w_diff : i_rem;
    o_rem    = w_sel << 1;
  end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider producing the unrounded rounder intermediate
// (sign_1, mant_2, expo_2, bit_s_record) plus a special-result bypass.
// Optional build macro DIV_ITER_EARLY_SPECIAL_EN: special operand pairs skip
// the iteration and report one cycle after acceptance.
//
// Handshake: an operand pair transfers on a clock edge where in_valid and
// in_ready are both high; a result transfers on an edge where out_valid and
// out_ready are both high. Once raised, out_valid and every result output
// hold steady until the result transfers.
module div_iter
  import fp_div_pkg::*;
#(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0] a,
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0] b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       sign_1,
  output logic [2*MANT_W+1:0]        mant_2,
  output logic [EXPO_W+1:0]          expo_2,
  output logic                       bit_s_record,
  output logic                       a_is_n0,
  output logic                       b_is_n0,
  output logic                       is_special,
  output logic [SIGN_W+EXPO_W+MANT_W-1:0] special_res,
  output logic                       invalid,
  output logic                       div_zero,
  output logic [1:0]                 o_dbg_state
);

  localparam int W     = SIGN_W + EXPO_W + MANT_W;
  localparam int QUO_W = quo_w(MANT_W);
  localparam int RW    = MANT_W + 2;
  localparam int CW    = $clog2(QUO_W);
  localparam logic [EXPO_W+1:0] BIAS     = (EXPO_W+2)'(exp_bias(EXPO_W));
  localparam logic [CW-1:0]     CNT_LAST = CW'(QUO_W - 1);
  localparam logic [W-1:0]      QNAN     = W'(qnan_bits(EXPO_W, MANT_W));

  // Operand fields.
  logic              w_sa, w_sb;
  logic [EXPO_W-1:0] w_ea, w_eb;
  logic [MANT_W-1:0] w_fa, w_fb;
  logic [MANT_W:0]   w_ma, w_mb;
  fp_class_t         w_ca, w_cb;

  // Capture-time results.
  logic              w_sign;
  logic              w_pre;
  logic [RW-1:0]     w_rem_init;
  logic [EXPO_W+1:0] w_expo;
  logic              w_spec, w_inv, w_dz;
  logic [W-1:0]      w_sres;

  // Iteration step.
  logic              w_q_bit;
  logic [RW-1:0]     w_step_rem;

  state_e            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [RW-1:0]     r_rem;
  logic [MANT_W:0]   r_mb;
  logic [QUO_W-1:0]  r_quo;
  logic              r_sign;
  logic [EXPO_W+1:0] r_expo;
  logic              r_a_n0, r_b_n0;
  logic              r_spec, r_inv, r_dz;
  logic [W-1:0]      r_sres;

  // Unpack and classify both operands; subnormals count as zero.
  always_comb begin
    w_sa = a[W-1];
    w_sb = b[W-1];
    w_ea = a[W-2:MANT_W];
    w_eb = b[W-2:MANT_W];
    w_fa = a[MANT_W-1:0];
    w_fb = b[MANT_W-1:0];
    w_ma = {1'b1, w_fa};
    w_mb = {1'b1, w_fb};
    w_ca.is_zero = (w_ea == '0);
    w_ca.is_inf  = (&w_ea) && (w_fa == '0);
    w_ca.is_nan  = (&w_ea) && (w_fa != '0);
    w_cb.is_zero = (w_eb == '0);
    w_cb.is_inf  = (&w_eb) && (w_fb == '0);
    w_cb.is_nan  = (&w_eb) && (w_fb != '0);
  end

  // Normalise the dividend so the first quotient bit is always 1, and form
  // the biased result exponent (may wrap negative or overflow).
  always_comb begin
    w_sign     = w_sa ^ w_sb;
    w_pre      = (w_ma < w_mb);
    w_rem_init = w_pre ? {w_ma, 1'b0} : {1'b0, w_ma};
    w_expo     = {2'b00, w_ea} - {2'b00, w_eb} + BIAS - {{(EXPO_W+1){1'b0}}, w_pre};
  end

  // Decide the special result, if any, in priority order.
  always_comb begin
    w_spec = 1'b0;
    w_inv  = 1'b0;
    w_dz   = 1'b0;
    w_sres = '0;
    if (w_ca.is_nan || w_cb.is_nan || (w_ca.is_zero && w_cb.is_zero) ||
        (w_ca.is_inf && w_cb.is_inf)) begin
      w_spec = 1'b1;
      w_inv  = 1'b1;
      w_sres = QNAN;
    end else if (w_cb.is_zero && !w_ca.is_inf) begin
      w_spec = 1'b1;
      w_dz   = 1'b1;
      w_sres = W'(inf_bits(w_sign, EXPO_W, MANT_W));
    end else if (w_ca.is_inf) begin
      w_spec = 1'b1;
      w_sres = W'(inf_bits(w_sign, EXPO_W, MANT_W));
    end else if (w_ca.is_zero || w_cb.is_inf) begin
      w_spec = 1'b1;
      w_sres = W'(zero_bits(w_sign, EXPO_W, MANT_W));
    end
  end

  div_iter_step #(
    .MANT_W (MANT_W)
  ) u_step (
    .i_rem   (r_rem),
    .i_mb    (r_mb),
    .o_q_bit (w_q_bit),
    .o_rem   (w_step_rem)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
`ifdef DIV_ITER_EARLY_SPECIAL_EN
          w_state_nxt = w_spec ? DONE : ITER;
`else
          w_state_nxt = ITER;
`endif
        end
      end
      ITER: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands in IDLE, shift in one quotient bit per ITER cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_mb   <= '0;
      r_quo  <= '0;
      r_sign <= 1'b0;
      r_expo <= '0;
      r_a_n0 <= 1'b0;
      r_b_n0 <= 1'b0;
      r_spec <= 1'b0;
      r_inv  <= 1'b0;
      r_dz   <= 1'b0;
      r_sres <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_cnt  <= '0;
      r_rem  <= w_rem_init;
      r_mb   <= w_mb;
      r_quo  <= '0;
      r_sign <= w_sign;
      r_expo <= w_expo;
      r_a_n0 <= !w_ca.is_zero;
      r_b_n0 <= !w_cb.is_zero;
      r_spec <= w_spec;
      r_inv  <= w_inv;
      r_dz   <= w_dz;
      r_sres <= w_sres;
    end else if (r_state == ITER) begin
      r_cnt  <= r_cnt + CW'(1);
      r_rem  <= w_step_rem;
      r_quo  <= {r_quo[QUO_W-2:0], w_q_bit};
    end
  end

  // Outputs come straight from registers, so they are stable in DONE.
  always_comb begin
    in_ready     = (r_state == IDLE);
    out_valid    = (r_state == DONE);
    sign_1       = r_sign;
    mant_2       = {1'b0, r_quo, {(MANT_W-1){1'b0}}};
    expo_2       = r_expo;
    bit_s_record = |r_rem;
    a_is_n0      = r_a_n0;
    b_is_n0      = r_b_n0;
    is_special   = r_spec;
    special_res  = r_sres;
    invalid      = r_inv;
    div_zero     = r_dz;
    o_dbg_state  = r_state;
  end

endmodule
